// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the game sequencer: FSM states, speed defaults and
// the level-to-period mapping.
package game_sequencer_pkg;

  localparam int DEF_PERIOD_BASE = 16;
  localparam int DEF_PERIOD_STEP = 2;
  localparam int LEVEL_W         = 3;
  localparam int STATE_W         = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_LOST      = 3'd4,
    ST_WON       = 3'd5
  } state_t;

  // Frames per tick at a given speed level, never faster than every 2 frames.
  function automatic int calc_period(input int base, input int step,
                                     input logic [LEVEL_W-1:0] level);
    int p;
    p = base - step * int'(level);
    return (p < 2) ? 2 : p;
  endfunction

endpackage

// File: rtl/game_sequencer_frame_divider.sv
// Vsync rising-edge detector and frame counter that raises a due pulse
// every 'period' frames.
module frame_divider #(
  parameter int PW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          clear,
  input  logic          hold,
  input  logic [PW-1:0] period,
  output logic          due
);

  logic          vsync_q;
  logic          frame_edge;
  logic [PW-1:0] count;
  logic [PW-1:0] cur_period;

  assign frame_edge = vsync & ~vsync_q;
  assign due        = frame_edge & ~hold & ~clear & (count == cur_period - PW'(1));

  // The period is latched at every count restart so a level change mid-interval
  // only takes effect on the following interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      count      <= '0;
      cur_period <= period;
    end else begin
      vsync_q <= vsync;
      if (clear) begin
        count      <= '0;
        cur_period <= period;
      end else if (frame_edge && !hold) begin
        if (due) begin
          count      <= '0;
          cur_period <= period;
        end else begin
          count <= count + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Snake game sequencer: paces move ticks off vsync, handles the tick/done
// handshake, pause, win/lose and speed levels.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int PERIOD_BASE      = DEF_PERIOD_BASE,
  parameter int PERIOD_STEP      = DEF_PERIOD_STEP,
  parameter int APPLES_PER_LEVEL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_vsync,
  input  logic               i_pause,
  input  logic               i_restart,
  input  logic               i_start,
  input  logic               i_apple_ready,
  input  logic               i_tick_done,
  input  logic               i_failure,
  input  logic               i_success,
  input  logic               i_eat,
  output logic               o_tick,
  output logic [STATE_W-1:0] o_state,
  output logic               o_failure,
  output logic               o_success,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_drop
);

  localparam int PW = $clog2(PERIOD_BASE + 1);
  localparam int AW = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;

  state_t             state;
  logic [AW-1:0]      apples;
  logic [LEVEL_W-1:0] level;
  logic [PW-1:0]      period;
  logic               due;
  logic               go;
  logic               clear;
  logic               hold;
  logic               live;

  assign period  = PW'(calc_period(PERIOD_BASE, PERIOD_STEP, level));
  assign go      = (state == ST_IDLE) & i_start & i_apple_ready;
  assign clear   = i_restart | go;
  assign hold    = !((state == ST_RUN) || (state == ST_WAIT_DONE));
  assign live    = (state == ST_RUN) || (state == ST_WAIT_DONE) || (state == ST_PAUSED);
  assign o_state = state;
  assign o_level = level;

  frame_divider #(.PW(PW)) u_div (
    .clk    (clk),
    .rst    (rst),
    .vsync  (i_vsync),
    .clear  (clear),
    .hold   (hold),
    .period (period),
    .due    (due)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      o_tick    <= 1'b0;
      o_drop    <= 1'b0;
      o_failure <= 1'b0;
      o_success <= 1'b0;
      level     <= '0;
      apples    <= '0;
    end else begin
      o_tick <= 1'b0;
      o_drop <= 1'b0;
      if (i_restart) begin
        state     <= ST_IDLE;
        o_failure <= 1'b0;
        o_success <= 1'b0;
        level     <= '0;
        apples    <= '0;
      end else begin
        if (i_eat && live) begin
          if (apples == AW'(APPLES_PER_LEVEL - 1)) begin
            apples <= '0;
            if (level != '1) level <= level + LEVEL_W'(1);
          end else begin
            apples <= apples + AW'(1);
          end
        end
        // Failure outranks success when both arrive together.
        if (live && i_failure) begin
          o_failure <= 1'b1;
          state     <= ST_LOST;
        end else if (live && i_success) begin
          o_success <= 1'b1;
          state     <= ST_WON;
        end else begin
          case (state)
            ST_IDLE: if (go) state <= ST_RUN;
            ST_RUN: begin
              if (due && i_apple_ready) begin
                o_tick <= 1'b1;
                state  <= ST_WAIT_DONE;
              end else begin
                if (due) o_drop <= 1'b1;
                if (i_pause) state <= ST_PAUSED;
              end
            end
            ST_WAIT_DONE: begin
              if (due) o_drop <= 1'b1;
              if (i_tick_done) state <= i_pause ? ST_PAUSED : ST_RUN;
            end
            ST_PAUSED: if (!i_pause) state <= ST_RUN;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with hand-computed tick/drop timing.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_vsync = 1'b0, i_pause = 1'b0, i_restart = 1'b0, i_start = 1'b0;
  logic       i_apple_ready = 1'b0, i_tick_done = 1'b0;
  logic       i_failure = 1'b0, i_success = 1'b0, i_eat = 1'b0;
  logic       o_tick, o_failure, o_success, o_drop;
  logic [2:0] o_state, o_level;

  int n_run = 0, n_fail = 0, both = 0;
  int ticks = 0, drops = 0;
  int n;

  always #5 clk = ~clk;
  always @(negedge clk) if (o_tick && o_drop) both++;

  game_sequencer dut (
    .clk(clk), .rst(rst), .i_vsync(i_vsync), .i_pause(i_pause),
    .i_restart(i_restart), .i_start(i_start), .i_apple_ready(i_apple_ready),
    .i_tick_done(i_tick_done), .i_failure(i_failure), .i_success(i_success),
    .i_eat(i_eat), .o_tick(o_tick), .o_state(o_state), .o_failure(o_failure),
    .o_success(o_success), .o_level(o_level), .o_drop(o_drop)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One vsync frame; o_tick/o_drop are sampled the cycle after the edge.
  task automatic frame(input int hi = 1);
    @(negedge clk) i_vsync = 1'b1;
    @(negedge clk);
    ticks += int'(o_tick);
    drops += int'(o_drop);
    repeat (hi - 1) @(negedge clk);
    i_vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input int k);
    repeat (k) frame();
  endtask

  task automatic to_tick(output int cnt);
    cnt   = -1;
    ticks = 0;
    for (int i = 1; i <= 40 && cnt < 0; i++) begin
      frame();
      if (ticks != 0) cnt = i;
    end
  endtask

  task automatic pulse_done();
    @(negedge clk) i_tick_done = 1'b1;
    @(negedge clk) i_tick_done = 1'b0;
  endtask

  task automatic eat(input int k);
    repeat (k) begin
      @(negedge clk) i_eat = 1'b1;
      @(negedge clk) i_eat = 1'b0;
    end
  endtask

  task automatic start_game();
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", o_state, 0);
    chk("rst_tick", o_tick, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_fail", o_failure, 0);
    chk("rst_succ", o_success, 0);
    chk("rst_level", o_level, 0);
    rst = 1'b0;

    // start without an apple must stay idle
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) chk("start_no_apple", o_state, 0);
    i_apple_ready = 1'b1;
    @(negedge clk) i_start = 1'b0;
    chk("start_run", o_state, 1);

    // first edge held high for 20 cycles still counts once
    ticks = 0; drops = 0;
    frame(20);
    frames(14);
    chk("no_tick_15", ticks, 0);
    frame();
    chk("tick_16", ticks, 1);
    chk("wait_done", o_state, 2);

    ticks = 0; drops = 0;
    frames(32);
    chk("wait_drops", drops, 2);
    chk("wait_no_tick", ticks, 0);
    chk("still_wait", o_state, 2);
    pulse_done();
    chk("done_run", o_state, 1);
    to_tick(n);
    chk("interval_16", n, 16);
    pulse_done();

    // no apple -> due tick dropped, stays RUN
    i_apple_ready = 1'b0;
    ticks = 0; drops = 0;
    frames(16);
    chk("noapple_drop", drops, 1);
    chk("noapple_tick", ticks, 0);
    chk("noapple_run", o_state, 1);
    i_apple_ready = 1'b1;
    to_tick(n);
    chk("after_drop_16", n, 16);

    // pause requested during WAIT_DONE, count frozen while paused
    drops = 0;
    frames(5);
    i_pause = 1'b1;
    pulse_done();
    chk("paused", o_state, 3);
    ticks = 0;
    frames(10);
    chk("paused_tick", ticks, 0);
    chk("paused_drop", drops, 0);
    chk("paused_hold", o_state, 3);
    @(negedge clk) i_pause = 1'b0;
    @(negedge clk) chk("unpause", o_state, 1);
    to_tick(n);
    chk("resume_11", n, 11);
    pulse_done();

    // speed levels
    eat(4);
    chk("level1", o_level, 1);
    to_tick(n);
    chk("lvl1_old_16", n, 16);
    pulse_done();
    to_tick(n);
    chk("lvl1_14", n, 14);
    pulse_done();
    eat(24);
    chk("level7", o_level, 7);
    to_tick(n);
    chk("lvl7_old_14", n, 14);
    pulse_done();
    to_tick(n);
    chk("lvl7_2", n, 2);
    pulse_done();
    eat(4);
    chk("level_sat", o_level, 7);
    to_tick(n);
    chk("sat_2", n, 2);
    pulse_done();

    // pause straight from RUN
    @(negedge clk) i_pause = 1'b1;
    @(negedge clk) chk("run_pause", o_state, 3);
    i_pause = 1'b0;
    @(negedge clk) chk("run_unpause", o_state, 1);

    // failure beats success
    @(negedge clk) begin i_failure = 1'b1; i_success = 1'b1; end
    @(negedge clk) begin i_failure = 1'b0; i_success = 1'b0; end
    chk("lost", o_state, 4);
    chk("lost_fail", o_failure, 1);
    chk("lost_succ", o_success, 0);
    ticks = 0;
    frames(20);
    chk("lost_no_tick", ticks, 0);
    @(negedge clk) i_pause = 1'b1;
    @(negedge clk) chk("lost_pause", o_state, 4);
    i_pause = 1'b0;
    @(negedge clk) i_restart = 1'b1;
    @(negedge clk) i_restart = 1'b0;
    chk("restart_state", o_state, 0);
    chk("restart_fail", o_failure, 0);
    chk("restart_succ", o_success, 0);
    chk("restart_level", o_level, 0);

    // win path
    start_game();
    @(negedge clk) i_success = 1'b1;
    @(negedge clk) i_success = 1'b0;
    chk("won", o_state, 5);
    chk("won_succ", o_success, 1);
    chk("won_fail", o_failure, 0);
    @(negedge clk) i_restart = 1'b1;
    @(negedge clk) i_restart = 1'b0;

    // reset abandons the handshake; late done ignored
    start_game();
    to_tick(n);
    chk("pre_rst_16", n, 16);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    pulse_done();
    chk("late_done_idle", o_state, 0);
    start_game();
    to_tick(n);
    chk("post_rst_16", n, 16);

    chk("tick_drop_overlap", both, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
